// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter one byte at a time.
// Launches a byte with tx_start, then paces itself on the registered tx_busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              byte_sent
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp_r;
    logic [ADDR_W-1:0] rp_r;
    logic              busy_q_r;
    state_t            state_r;
    state_t            state_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              done_s;

    assign full  = (count == FULL_CNT);
    assign empty = (count == {(ADDR_W + 1){1'b0}});

    // Next-state and handshake decode; a pop in the same cycle frees a slot for a write.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable && !empty) begin
                    pop_s   = 1'b1;
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (busy_q_r) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_START;
                end
            end
            S_WAIT: begin
                if (!busy_q_r) begin
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        push_s = wr_en && (!full || pop_s);
        drop_s = wr_en && full && !pop_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pointers, occupancy, launched byte and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r      <= {ADDR_W{1'b0}};
            rp_r      <= {ADDR_W{1'b0}};
            count     <= {(ADDR_W + 1){1'b0}};
            tx_data   <= 8'h00;
            busy_q_r  <= 1'b0;
            tx_start  <= 1'b0;
            byte_sent <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            busy_q_r  <= tx_busy;
            tx_start  <= (state_s == S_START);
            byte_sent <= done_s;
            overflow  <= drop_s;
            if (push_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (pop_s) begin
                tx_data <= mem[rp_r];
                rp_r    <= rp_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wp_r] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a transmitter model answers tx_start,
// and an in-order byte queue serves as the reference for everything launched.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
    logic          byte_sent;

    int n_checks = 0;
    int n_fail   = 0;

    int dly_cfg  = 5;
    int hold_cfg = 20;
    int m_cnt    = 0;
    int m_hold   = 0;

    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];
    int         sent_cnt     = 0;
    int         ovf_cnt      = 0;
    int         launch_cnt   = 0;
    int         unstable_cnt = 0;
    logic       prev_start   = 1'b0;
    logic       in_flight    = 1'b0;
    logic [7:0] held         = 8'h00;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .byte_sent (byte_sent)
    );

    // Transmitter model: busy rises dly_cfg edges after tx_start is seen, stays hold_cfg cycles.
    always @(posedge clk) begin
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                tx_busy <= 1'b1;
                m_hold  <= hold_cfg;
            end
        end else if (tx_busy) begin
            if (m_hold <= 1) tx_busy <= 1'b0;
            m_hold <= m_hold - 1;
        end else if (tx_start) begin
            m_cnt <= dly_cfg;
        end
    end

    // Monitor: records each launched byte and watches tx_data stability while in flight.
    always @(negedge clk) begin
        if (rst) begin
            prev_start <= 1'b0;
            in_flight  <= 1'b0;
        end else begin
            prev_start <= tx_start;
            if (tx_start && !prev_start) begin
                rx_q.push_back(tx_data);
                held       <= tx_data;
                in_flight  <= 1'b1;
                launch_cnt <= launch_cnt + 1;
            end else if (in_flight) begin
                if (tx_data !== held) unstable_cnt <= unstable_cnt + 1;
                if (byte_sent) in_flight <= 1'b0;
            end
            if (byte_sent) sent_cnt <= sent_cnt + 1;
            if (overflow)  ovf_cnt  <= ovf_cnt + 1;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sent(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sent_cnt >= target) break;
            cyc();
        end
        ok = (sent_cnt >= target);
    endtask

    task automatic wait_in_wait(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_busy && !tx_start && count != 0) break;
            cyc();
        end
        ok = (tx_busy && !tx_start);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        repeat (3) cyc();
        n_checks++; if (count !== 5'd0)    begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        n_checks++; if (byte_sent !== 1'b0) begin n_fail++; $display("FAIL rst_byte_sent: got %b want 0", byte_sent); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        rst = 1'b0;
        cyc();
        n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL post_rst_idle: got empty=%b count=%0d want 1/0", empty, count); end
    endtask

    task automatic test_single();
        bit ok;
        int base_sent = sent_cnt;
        int base_uns  = unstable_cnt;
        dly_cfg = 5; hold_cfg = 20; enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        cyc();
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL single_write: got count=%0d empty=%b want 1/0", count, empty); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %b want 0", tx_start); end
        cyc();
        n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_launch: got start=%b data=%h want 1/a5", tx_start, tx_data); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_pop: got %0d want 0", count); end
        for (int i = 0; i < 50 && !tx_busy; i++) cyc();
        n_checks++; if (tx_busy !== 1'b1 || tx_start !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got busy=%b start=%b want 1/1", tx_busy, tx_start); end
        cyc();
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start_hold: got %b want 1", tx_start); end
        cyc();
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: got %b want 0", tx_start); end
        wait_sent(base_sent + 1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_sent_wait: got %0d want %0d", sent_cnt - base_sent, 1); end
        repeat (10) cyc();
        n_checks++; if (sent_cnt - base_sent !== 1) begin n_fail++; $display("FAIL single_sent_count: got %0d want 1", sent_cnt - base_sent); end
        n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_rx: got size=%0d want 1 byte a5", rx_q.size()); end
        n_checks++; if (unstable_cnt !== base_uns) begin n_fail++; $display("FAIL single_stable: got %0d changes want 0", unstable_cnt - base_uns); end
        rx_q.delete();
    endtask

    task automatic test_burst_overflow();
        bit ok;
        int base_sent = sent_cnt;
        int base_ovf  = ovf_cnt;
        dly_cfg = 2; hold_cfg = 4; enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            exp_q.push_back(8'(i));
            cyc();
        end
        wr_data = 8'hFF;
        cyc();
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL burst_ovf_pulse: got %b want 1", overflow); end
        n_checks++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL burst_full: got full=%b count=%0d want 1/16", full, count); end
        cyc();
        n_checks++; if (overflow !== 1'b0 || ovf_cnt - base_ovf !== 1) begin n_fail++; $display("FAIL burst_ovf_once: got now=%b pulses=%0d want 0/1", overflow, ovf_cnt - base_ovf); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL burst_count_held: got %0d want 16", count); end
        enable = 1'b1;
        wait_sent(base_sent + 16, 16 * 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_sent_wait: got %0d want 16", sent_cnt - base_sent); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL burst_rx_size: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL burst_empty: got %b want 1", empty); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        bit ok;
        int base_sent;
        enable = 1'b1; dly_cfg = 2; hold_cfg = 4;
        for (int r = 0; r < 2; r++) begin
            base_sent = sent_cnt;
            for (int i = 0; i < 10; i++) begin
                wr_en = 1'b1; wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
                cyc();
            end
            wr_en = 1'b0;
            wait_sent(base_sent + 10, 10 * 40, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_sent_wait[%0d]: got %0d want 10", r, sent_cnt - base_sent); end
            n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_rx_size[%0d]: got %0d want %0d", r, rx_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte[%0d][%0d]: got %h want %h", r, i, rx_q[i], exp_q[i]); end
            end
            rx_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_simul_full();
        bit ok;
        int base_sent = sent_cnt;
        enable = 1'b0; dly_cfg = 1; hold_cfg = 3;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            exp_q.push_back(wr_data);
            cyc();
        end
        n_checks++; if (count !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL simul_prefill: got count=%0d full=%b want 16/1", count, full); end
        enable = 1'b1; wr_data = 8'h77;
        exp_q.push_back(8'h77);
        cyc();
        wr_en = 1'b0;
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL simul_count: got %0d want 16", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow: got %b want 0", overflow); end
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL simul_launch: got %b want 1", tx_start); end
        wait_sent(base_sent + 17, 17 * 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_sent_wait: got %0d want 17", sent_cnt - base_sent); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL simul_rx_size: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL simul_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_enable_gate();
        bit ok;
        int base_sent   = sent_cnt;
        int base_launch = launch_cnt;
        enable = 1'b1; dly_cfg = 3; hold_cfg = 8;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            exp_q.push_back(wr_data);
            cyc();
        end
        wr_en = 1'b0;
        wait_in_wait(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gate_reach_wait: got busy=%b start=%b want 1/0", tx_busy, tx_start); end
        enable = 1'b0;
        wait_sent(base_sent + 1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gate_inflight_done: got %0d want 1", sent_cnt - base_sent); end
        repeat (30) cyc();
        n_checks++; if (launch_cnt - base_launch !== 1 || tx_start !== 1'b0) begin n_fail++; $display("FAIL gate_held: got launches=%0d start=%b want 1/0", launch_cnt - base_launch, tx_start); end
        n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL gate_count: got %0d want 2", count); end
        enable = 1'b1;
        cyc();
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL gate_resume: got %b want 1", tx_start); end
        wait_sent(base_sent + 3, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gate_sent_wait: got %0d want 3", sent_cnt - base_sent); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL gate_rx_size: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gate_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int base_sent;
        int base_launch;
        enable = 1'b1; dly_cfg = 3; hold_cfg = 10;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            cyc();
        end
        wr_en = 1'b0;
        wait_in_wait(100, ok);
        n_checks++; if (!ok || count !== 5'd3) begin n_fail++; $display("FAIL rstw_setup: got count=%0d want 3 in WAIT", count); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rstw_clear: got count=%0d empty=%b want 0/1", count, empty); end
        n_checks++; if (tx_start !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL rstw_outputs: got start=%b full=%b want 0/0", tx_start, full); end
        cyc();
        rst = 1'b0;
        base_sent   = sent_cnt;
        base_launch = launch_cnt;
        repeat (40) cyc();
        n_checks++; if (sent_cnt !== base_sent) begin n_fail++; $display("FAIL rstw_no_sent: got %0d pulses want 0", sent_cnt - base_sent); end
        n_checks++; if (launch_cnt !== base_launch || empty !== 1'b1) begin n_fail++; $display("FAIL rstw_idle: got launches=%0d empty=%b want 0/1", launch_cnt - base_launch, empty); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        int base_sent = sent_cnt;
        int base_ovf  = ovf_cnt;
        int base_uns  = unstable_cnt;
        int pushed    = 0;
        dly_cfg  = $urandom_range(1, 6);
        hold_cfg = $urandom_range(3, 10);
        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && (pushed - (sent_cnt - base_sent)) < DEPTH) begin
                wr_en = 1'b1; wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
            cyc();
        end
        wr_en = 1'b0; enable = 1'b1;
        wait_sent(base_sent + pushed, pushed * 30 + 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_sent_wait: got %0d want %0d", sent_cnt - base_sent, pushed); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_rx_size: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (ovf_cnt !== base_ovf) begin n_fail++; $display("FAIL rand_overflow: got %0d pulses want 0", ovf_cnt - base_ovf); end
        n_checks++; if (unstable_cnt !== base_uns) begin n_fail++; $display("FAIL rand_stable: got %0d changes want 0", unstable_cnt - base_uns); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rand_empty: got %b want 1", empty); end
        rx_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_overflow();
        test_wrap();
        test_simul_full();
        test_enable_gate();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
